// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals between two requesters, the arbiter and the shared ALU.
// The arbiter uses slave; requesters plus the ALU sit on master.
interface alu_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 6
);
   logic                  req_valid0, req_valid1;
   logic                  req_ready0, req_ready1;
   logic [CTRL_WIDTH-1:0] req_ctrl0, req_ctrl1;
   logic                  req_branch_op0, req_branch_op1;
   logic [DATA_WIDTH-1:0] req_opA0, req_opA1;
   logic [DATA_WIDTH-1:0] req_opB0, req_opB1;

   logic                  rsp_valid0, rsp_valid1;
   logic                  rsp_ready0, rsp_ready1;
   logic [DATA_WIDTH-1:0] rsp_result;
   logic                  rsp_branch;

   logic                  alu_branch_op;
   logic [CTRL_WIDTH-1:0] alu_ctrl;
   logic [DATA_WIDTH-1:0] alu_operand_A, alu_operand_B;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_branch;

   modport slave (
      input  req_valid0, req_valid1, req_ctrl0, req_ctrl1,
      input  req_branch_op0, req_branch_op1, req_opA0, req_opA1, req_opB0, req_opB1,
      output req_ready0, req_ready1,
      output rsp_valid0, rsp_valid1, rsp_result, rsp_branch,
      input  rsp_ready0, rsp_ready1,
      output alu_branch_op, alu_ctrl, alu_operand_A, alu_operand_B,
      input  alu_result, alu_branch
   );

   modport master (
      output req_valid0, req_valid1, req_ctrl0, req_ctrl1,
      output req_branch_op0, req_branch_op1, req_opA0, req_opA1, req_opB0, req_opB1,
      input  req_ready0, req_ready1,
      input  rsp_valid0, rsp_valid1, rsp_result, rsp_branch,
      output rsp_ready0, rsp_ready1,
      input  alu_branch_op, alu_ctrl, alu_operand_A, alu_operand_B,
      output alu_result, alu_branch
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; stats counters via ALU_ARB_STATS_EN.
// Result registered in one slot (1-cycle latency); requests stall while the slot is held and not accepted.
module alu_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 6
`ifdef ALU_ARB_STATS_EN
   ,parameter int CNT_WIDTH = 16
`endif
) (
   input  logic                 clock,
   input  logic                 reset,
   alu_arbiter_if.slave         bus
`ifdef ALU_ARB_STATS_EN
   ,output logic [CNT_WIDTH-1:0] grant_cnt0
   ,output logic [CNT_WIDTH-1:0] grant_cnt1
   ,output logic [CNT_WIDTH-1:0] conflict_cnt
`endif
);

   typedef enum logic {S_EMPTY, S_FULL} slot_e;

   slot_e                 state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  branch_q, branch_d;

   logic                  accept, slot_free, grant0, grant1;
   logic [CTRL_WIDTH-1:0] ctrl_mux;
   logic                  bop_mux;
   logic [DATA_WIDTH-1:0] opa_mux, opb_mux;

   // ptr_q names the requester that wins when both are valid.
   always_comb begin : arb
      accept    = (state_q == S_FULL) && (owner_q ? bus.rsp_ready1 : bus.rsp_ready0);
      slot_free = (state_q == S_EMPTY) || accept;
      grant0    = slot_free && bus.req_valid0 && (!bus.req_valid1 || !ptr_q);
      grant1    = slot_free && bus.req_valid1 && (!bus.req_valid0 ||  ptr_q);
   end

   always_comb begin : alu_drive
      ctrl_mux = '0;
      bop_mux  = 1'b0;
      opa_mux  = '0;
      opb_mux  = '0;
      if (grant0) begin
         ctrl_mux = bus.req_ctrl0;
         bop_mux  = bus.req_branch_op0;
         opa_mux  = bus.req_opA0;
         opb_mux  = bus.req_opB0;
      end else if (grant1) begin
         ctrl_mux = bus.req_ctrl1;
         bop_mux  = bus.req_branch_op1;
         opa_mux  = bus.req_opA1;
         opb_mux  = bus.req_opB1;
      end
   end

   // A grant in the same cycle as an accept overwrites the slot, keeping one result per cycle.
   always_comb begin : next_state
      state_d  = state_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      result_d = result_q;
      branch_d = branch_q;
      if (grant0 || grant1) begin
         state_d  = S_FULL;
         owner_d  = grant1;
         ptr_d    = grant0;
         result_d = bus.alu_result;
         branch_d = bus.alu_branch;
      end else if (accept) begin
         state_d  = S_EMPTY;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= S_EMPTY;
         owner_q  <= 1'b0;
         ptr_q    <= 1'b0;
         result_q <= '0;
         branch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         result_q <= result_d;
         branch_q <= branch_d;
      end
   end

   assign bus.req_ready0    = grant0;
   assign bus.req_ready1    = grant1;
   assign bus.rsp_valid0    = (state_q == S_FULL) && !owner_q;
   assign bus.rsp_valid1    = (state_q == S_FULL) &&  owner_q;
   assign bus.rsp_result    = result_q;
   assign bus.rsp_branch    = branch_q;
   assign bus.alu_ctrl      = ctrl_mux;
   assign bus.alu_branch_op = bop_mux;
   assign bus.alu_operand_A = opa_mux;
   assign bus.alu_operand_B = opb_mux;

`ifdef ALU_ARB_STATS_EN
   logic [CNT_WIDTH-1:0] gcnt0_q, gcnt1_q, ccnt_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         gcnt0_q <= '0;
         gcnt1_q <= '0;
         ccnt_q  <= '0;
      end else begin
         if (grant0 && (gcnt0_q != '1)) gcnt0_q <= gcnt0_q + CNT_WIDTH'(1);
         if (grant1 && (gcnt1_q != '1)) gcnt1_q <= gcnt1_q + CNT_WIDTH'(1);
         if (bus.req_valid0 && bus.req_valid1 && slot_free && (ccnt_q != '1))
            ccnt_q <= ccnt_q + CNT_WIDTH'(1);
      end
   end

   assign grant_cnt0   = gcnt0_q;
   assign grant_cnt1   = gcnt1_q;
   assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed multi-cycle sequences, then random traffic vs a scoreboard.
module tb_alu_arbiter;
   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_AND = 6'b000001;
   localparam logic [5:0] OP_OR  = 6'b000010;
   localparam logic [5:0] OP_SUB = 6'b001000;
   localparam logic [5:0] OP_BEQ = 6'b010000;
   localparam logic [5:0] OP_BNE = 6'b010001;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   alu_arbiter_if #(.DATA_WIDTH(32), .CTRL_WIDTH(6)) bus ();

`ifdef ALU_ARB_STATS_EN
   logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
   alu_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(6), .CNT_WIDTH(16)) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt));
`else
   alu_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(6)) dut (
      .clock(clock), .reset(reset), .bus(bus));
`endif

   function automatic logic [31:0] alu_res_f(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         OP_ADD:         return a + b;
         OP_SUB:         return a - b;
         OP_AND:         return a & b;
         OP_OR:          return a | b;
         OP_BEQ, OP_BNE: return a - b;
         default:        return a ^ b;
      endcase
   endfunction

   function automatic logic alu_br_f(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
      return ((c == OP_BEQ) && (a == b)) || ((c == OP_BNE) && (a != b));
   endfunction

   // Stand-in for the core ALU; branch is computed regardless of branch_op.
   always_comb begin
      bus.alu_result = alu_res_f(bus.alu_ctrl, bus.alu_operand_A, bus.alu_operand_B);
      bus.alu_branch = alu_br_f(bus.alu_ctrl, bus.alu_operand_A, bus.alu_operand_B);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int r, input logic v, input logic [5:0] c, input logic bop,
                          input logic [31:0] a, input logic [31:0] b);
      if (r == 0) begin
         bus.req_valid0 = v; bus.req_ctrl0 = c; bus.req_branch_op0 = bop;
         bus.req_opA0 = a;   bus.req_opB0 = b;
      end else begin
         bus.req_valid1 = v; bus.req_ctrl1 = c; bus.req_branch_op1 = bop;
         bus.req_opA1 = a;   bus.req_opB1 = b;
      end
   endtask

   task automatic idle_all;
      set_req(0, 1'b0, 6'd0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b0, 6'd0, 1'b0, 32'd0, 32'd0);
      bus.rsp_ready0 = 1'b1;
      bus.rsp_ready1 = 1'b1;
   endtask

   task automatic do_reset;
      idle_all();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Scoreboard state for the random phase.
   typedef struct {
      logic        owner;
      logic [31:0] res;
      logic        br;
   } exp_t;

   exp_t        q[$];
   exp_t        m_e;
   logic        mon_en = 1'b0;
   logic        hs0 = 1'b0, hs1 = 1'b0;
   logic        p0 = 1'b0, p1 = 1'b0;
   logic [5:0]  p0_c, p1_c;
   logic        p0_bop, p1_bop;
   logic [31:0] p0_a, p0_b, p1_a, p1_b;
   logic        m_acc, m_free;
   int          m_g;
   int          last_g = 1;

   always @(negedge clock) begin
      if (mon_en) begin
         if (p0) begin
            total++;
            assert ({bus.req_ctrl0, bus.req_branch_op0, bus.req_opA0, bus.req_opB0} == {p0_c, p0_bop, p0_a, p0_b})
            else begin
               bad++;
               $display("FAIL req0_stable: got %h/%h held %h/%h", bus.req_ctrl0, bus.req_opA0, p0_c, p0_a);
            end
         end
         if (p1) begin
            total++;
            assert ({bus.req_ctrl1, bus.req_branch_op1, bus.req_opA1, bus.req_opB1} == {p1_c, p1_bop, p1_a, p1_b})
            else begin
               bad++;
               $display("FAIL req1_stable: got %h/%h held %h/%h", bus.req_ctrl1, bus.req_opA1, p1_c, p1_a);
            end
         end

         m_acc = 1'b0;
         if (q.size() > 0) begin
            m_e = q[0];
            chk1("rnd_rsp_valid0", bus.rsp_valid0, m_e.owner == 1'b0);
            chk1("rnd_rsp_valid1", bus.rsp_valid1, m_e.owner == 1'b1);
            chk("rnd_rsp_result", bus.rsp_result, m_e.res);
            chk1("rnd_rsp_branch", bus.rsp_branch, m_e.br);
            m_acc = m_e.owner ? bus.rsp_ready1 : bus.rsp_ready0;
            if (m_acc) void'(q.pop_front());
         end else begin
            chk1("rnd_idle_valid0", bus.rsp_valid0, 1'b0);
            chk1("rnd_idle_valid1", bus.rsp_valid1, 1'b0);
         end
         m_free = (q.size() == 0);

         // Contention goes to whichever requester was not granted most recently.
         m_g = -1;
         if (m_free) begin
            if (bus.req_valid0 && bus.req_valid1) m_g = (last_g == 0) ? 1 : 0;
            else if (bus.req_valid0)              m_g = 0;
            else if (bus.req_valid1)              m_g = 1;
         end
         chk1("rnd_ready0", bus.req_ready0, m_g == 0);
         chk1("rnd_ready1", bus.req_ready1, m_g == 1);

         if (m_g == 0) begin
            chk("rnd_alu_ctrl", {26'd0, bus.alu_ctrl}, {26'd0, bus.req_ctrl0});
            chk("rnd_alu_a", bus.alu_operand_A, bus.req_opA0);
            chk("rnd_alu_b", bus.alu_operand_B, bus.req_opB0);
            m_e.owner = 1'b0;
            m_e.res   = alu_res_f(bus.req_ctrl0, bus.req_opA0, bus.req_opB0);
            m_e.br    = alu_br_f(bus.req_ctrl0, bus.req_opA0, bus.req_opB0);
            q.push_back(m_e);
            last_g = 0;
         end else if (m_g == 1) begin
            chk("rnd_alu_ctrl", {26'd0, bus.alu_ctrl}, {26'd0, bus.req_ctrl1});
            chk("rnd_alu_a", bus.alu_operand_A, bus.req_opA1);
            chk("rnd_alu_b", bus.alu_operand_B, bus.req_opB1);
            m_e.owner = 1'b1;
            m_e.res   = alu_res_f(bus.req_ctrl1, bus.req_opA1, bus.req_opB1);
            m_e.br    = alu_br_f(bus.req_ctrl1, bus.req_opA1, bus.req_opB1);
            q.push_back(m_e);
            last_g = 1;
         end else begin
            chk("rnd_alu_idle", {25'd0, bus.alu_branch_op, bus.alu_ctrl} | bus.alu_operand_A | bus.alu_operand_B, 32'd0);
         end

         hs0 = bus.req_valid0 && bus.req_ready0;
         hs1 = bus.req_valid1 && bus.req_ready1;
         p0  = bus.req_valid0 && !bus.req_ready0;
         p1  = bus.req_valid1 && !bus.req_ready1;
         p0_c = bus.req_ctrl0; p0_bop = bus.req_branch_op0; p0_a = bus.req_opA0; p0_b = bus.req_opB0;
         p1_c = bus.req_ctrl1; p1_bop = bus.req_branch_op1; p1_a = bus.req_opA1; p1_b = bus.req_opB1;
      end
   end

   typedef struct {
      int          r;
      logic [5:0]  c;
      logic        bop;
      logic [31:0] a, b, res;
      logic        br;
   } vec_t;

   vec_t       vt[8];
   logic [5:0] ops[7];

   initial begin
      vt[0] = '{0, OP_ADD, 1'b0, 32'd4,          32'd5,          32'd9,          1'b0};
      vt[1] = '{1, OP_SUB, 1'b0, 32'd10,         32'hFFFF_FFFB,  32'd15,         1'b0};
      vt[2] = '{1, OP_BEQ, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1};
      vt[3] = '{1, OP_BNE, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b0};
      vt[4] = '{0, OP_ADD, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
      vt[5] = '{0, OP_BEQ, 1'b0, 32'd7,          32'd7,          32'd0,          1'b1};
      vt[6] = '{1, OP_AND, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0};
      vt[7] = '{0, OP_SUB, 1'b0, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_BEQ, OP_BNE, 6'b000111};

      // Reset state
      do_reset();
      @(negedge clock);
      chk1("reset_rsp_valid0", bus.rsp_valid0, 1'b0);
      chk1("reset_rsp_valid1", bus.rsp_valid1, 1'b0);
      chk("reset_rsp_result", bus.rsp_result, 32'd0);
      chk1("reset_rsp_branch", bus.rsp_branch, 1'b0);
      chk1("reset_ready0", bus.req_ready0, 1'b0);
      chk("reset_alu_ctrl", {26'd0, bus.alu_ctrl}, 32'd0);
      tick();

      // Single transactions from the vector table
      foreach (vt[i]) begin
         set_req(vt[i].r, 1'b1, vt[i].c, vt[i].bop, vt[i].a, vt[i].b);
         @(negedge clock);
         chk1("vec_ready0", bus.req_ready0, vt[i].r == 0);
         chk1("vec_ready1", bus.req_ready1, vt[i].r == 1);
         chk("vec_alu_ctrl", {26'd0, bus.alu_ctrl}, {26'd0, vt[i].c});
         chk("vec_alu_a", bus.alu_operand_A, vt[i].a);
         chk("vec_alu_b", bus.alu_operand_B, vt[i].b);
         chk1("vec_alu_bop", bus.alu_branch_op, vt[i].bop);
         tick();
         set_req(vt[i].r, 1'b0, 6'd0, 1'b0, 32'd0, 32'd0);
         @(negedge clock);
         chk1("vec_rsp_valid0", bus.rsp_valid0, vt[i].r == 0);
         chk1("vec_rsp_valid1", bus.rsp_valid1, vt[i].r == 1);
         chk("vec_rsp_result", bus.rsp_result, vt[i].res);
         chk1("vec_rsp_branch", bus.rsp_branch, vt[i].br);
         chk("vec_alu_idle", {26'd0, bus.alu_ctrl} | bus.alu_operand_A, 32'd0);
         tick();
      end

      // Both requesters held valid: alternating owners at one result per cycle
      do_reset();
      set_req(0, 1'b1, OP_ADD, 1'b0, 32'd4, 32'd5);
      set_req(1, 1'b1, OP_SUB, 1'b0, 32'd10, 32'hFFFF_FFFB);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk1("rr_ready0", bus.req_ready0, (k % 2) == 0);
         chk1("rr_ready1", bus.req_ready1, (k % 2) == 1);
         if (k > 0) begin
            chk1("rr_rsp_valid0", bus.rsp_valid0, ((k - 1) % 2) == 0);
            chk1("rr_rsp_valid1", bus.rsp_valid1, ((k - 1) % 2) == 1);
            chk("rr_rsp_result", bus.rsp_result, ((k - 1) % 2 == 0) ? 32'd9 : 32'd15);
         end
         tick();
      end
      set_req(0, 1'b0, 6'd0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b0, 6'd0, 1'b0, 32'd0, 32'd0);
      @(negedge clock);
      chk1("rr_last_valid1", bus.rsp_valid1, 1'b1);
      chk("rr_last_result", bus.rsp_result, 32'd15);
`ifdef ALU_ARB_STATS_EN
      chk("stat_grant0", {16'd0, grant_cnt0}, 32'd2);
      chk("stat_grant1", {16'd0, grant_cnt1}, 32'd2);
      chk("stat_conflict", {16'd0, conflict_cnt}, 32'd4);
`endif
      tick();

      // Owner stalls: slot held, both readies low, then same-cycle accept and regrant
      set_req(0, 1'b1, OP_ADD, 1'b0, 32'd4, 32'd5);
      bus.rsp_ready0 = 1'b0;
      @(negedge clock);
      chk1("hold_first_grant", bus.req_ready0, 1'b1);
      tick();
      set_req(0, 1'b0, 6'd0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b1, OP_SUB, 1'b0, 32'd10, 32'hFFFF_FFFB);
      for (int h = 0; h < 3; h++) begin
         @(negedge clock);
         chk1("hold_rsp_valid0", bus.rsp_valid0, 1'b1);
         chk("hold_rsp_result", bus.rsp_result, 32'd9);
         chk1("hold_ready0", bus.req_ready0, 1'b0);
         chk1("hold_ready1", bus.req_ready1, 1'b0);
         tick();
      end
      bus.rsp_ready0 = 1'b1;
      @(negedge clock);
      chk1("b2b_ready1", bus.req_ready1, 1'b1);
      chk("b2b_alu_a", bus.alu_operand_A, 32'd10);
      tick();
      set_req(1, 1'b0, 6'd0, 1'b0, 32'd0, 32'd0);
      @(negedge clock);
      chk1("b2b_rsp_valid1", bus.rsp_valid1, 1'b1);
      chk1("b2b_rsp_valid0", bus.rsp_valid0, 1'b0);
      chk("b2b_rsp_result", bus.rsp_result, 32'd15);
      tick();

      // Reset discards a pending response owned by requester 1
      set_req(1, 1'b1, OP_SUB, 1'b0, 32'd10, 32'hFFFF_FFFB);
      bus.rsp_ready1 = 1'b0;
      tick();
      set_req(1, 1'b0, 6'd0, 1'b0, 32'd0, 32'd0);
      @(negedge clock);
      chk1("rst1_pre_valid1", bus.rsp_valid1, 1'b1);
      reset = 1'b0;
      tick();
      @(negedge clock);
      chk1("rst1_valid0", bus.rsp_valid0, 1'b0);
      chk1("rst1_valid1", bus.rsp_valid1, 1'b0);
      chk("rst1_result", bus.rsp_result, 32'd0);
      reset = 1'b1;
      bus.rsp_ready1 = 1'b1;
      tick();
      set_req(0, 1'b1, OP_ADD, 1'b0, 32'd4, 32'd5);
      set_req(1, 1'b1, OP_SUB, 1'b0, 32'd10, 32'hFFFF_FFFB);
      @(negedge clock);
      chk1("rst1_first_ready0", bus.req_ready0, 1'b1);
      chk1("rst1_first_ready1", bus.req_ready1, 1'b0);
      tick();
      idle_all();
      tick();
      tick();

      // Reset returns the pointer to requester 0 even after requester 0 was just granted
      set_req(0, 1'b1, OP_ADD, 1'b0, 32'd1, 32'd2);
      bus.rsp_ready0 = 1'b0;
      tick();
      set_req(0, 1'b0, 6'd0, 1'b0, 32'd0, 32'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      bus.rsp_ready0 = 1'b1;
      set_req(0, 1'b1, OP_ADD, 1'b0, 32'd4, 32'd5);
      set_req(1, 1'b1, OP_SUB, 1'b0, 32'd10, 32'hFFFF_FFFB);
      @(negedge clock);
      chk1("rst0_ptr_ready0", bus.req_ready0, 1'b1);
      chk1("rst0_ptr_ready1", bus.req_ready1, 1'b0);
      tick();

      // Random traffic against the scoreboard
      do_reset();
      q.delete();
      last_g = 1;
      hs0 = 1'b0; hs1 = 1'b0; p0 = 1'b0; p1 = 1'b0;
      mon_en = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!(bus.req_valid0 && !hs0)) begin
            logic [31:0] a;
            a = $urandom;
            set_req(0, ($urandom_range(0, 2) != 0), ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                    a, ($urandom_range(0, 3) == 0) ? a : $urandom);
         end
         if (!(bus.req_valid1 && !hs1)) begin
            logic [31:0] a;
            a = $urandom;
            set_req(1, ($urandom_range(0, 2) != 0), ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                    a, ($urandom_range(0, 3) == 0) ? a : $urandom);
         end
         bus.rsp_ready0 = ($urandom_range(0, 3) != 0);
         bus.rsp_ready1 = ($urandom_range(0, 3) != 0);
         tick();
      end
      mon_en = 1'b0;
      idle_all();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the execute stage and a multi-cycle helper such as an address or branch-target sequencer.
- Uses a round-robin grant and a valid/ready handshake on both the request and response sides.
- Drives the ALU inputs from the granted requester and captures ALU_result/branch into one registered response slot, returned to the owner one cycle later.
- Instantiated beside the ALU in the core; the ALU itself is unchanged.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CTRL_WIDTH, 6, ALU_Control width.
- CNT_WIDTH, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- req_valid0 / req_valid1  in  1  request present from requester 0 / 1.
- req_ready0 / req_ready1  out  1  grant; the request is consumed when valid and ready are both 1.
- req_ctrl0 / req_ctrl1  in  CTRL_WIDTH  ALU_Control encoding.
- req_branch_op0 / req_branch_op1  in  1  branch_op.
- req_opA0 / req_opA1, req_opB0 / req_opB1  in  DATA_WIDTH  operands.
- rsp_valid0 / rsp_valid1  out  1  response slot holds a result owned by requester 0 / 1.
- rsp_ready0 / rsp_ready1  in  1  owner accepts the response.
- rsp_result  out  DATA_WIDTH  registered ALU_result.
- rsp_branch  out  1  registered branch flag.
- alu_branch_op  out  1  to ALU branch_op.
- alu_ctrl  out  CTRL_WIDTH  to ALU ALU_Control.
- alu_operand_A, alu_operand_B  out  DATA_WIDTH  to ALU operands.
- alu_result  in  DATA_WIDTH  from ALU ALU_result.
- alu_branch  in  1  from ALU branch.

Behaviour:
- Reset (reset==0 at posedge):
  - rsp_valid0 = rsp_valid1 = 0, rsp_result = 0, rsp_branch = 0.
  - Owner register = 0; round-robin pointer favours requester 0.
  - Any pending response is discarded. Reset overrides all other events in that cycle.
- Slot state is a two-state FSM, EMPTY / FULL:
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY when the owner accepts (rsp_validN && rsp_readyN) and there is no new grant in the same cycle.
  - FULL -> FULL when the owner accepts and a new grant occurs in the same cycle; the slot is overwritten, giving back-to-back throughput of one per cycle.
- Slot free (combinational) = EMPTY, or FULL and accepted this cycle.
- Grant (combinational):
  - Slot not free: both req_ready are 0.
  - Slot free, exactly one req_valid: that requester is granted.
  - Slot free, both valid: the requester selected by the pointer is granted.
  - On every grant the pointer moves to the non-granted requester.
  - req_ready may depend on the other requester's valid. It never depends on the requester's own data.
- Requester obligation: hold ctrl, branch_op and operands stable while valid && !ready. A bench assertion checks this.
- ALU drive (combinational):
  - Granted requester's fields drive the alu_* outputs.
  - With no grant, alu_ctrl = 0, alu_branch_op = 0, operands = 0.
- Capture: on a grant edge, rsp_result <= alu_result, rsp_branch <= alu_branch, owner <= granted index.
- Latency: exactly 1 cycle from request handshake to rsp_validN = 1.
- Response hold: rsp_result/rsp_branch stay stable until accepted. rsp_valid of the non-owner is always 0.
- rsp_branch is passed through unmasked; it is meaningful only when branch_op was 1.
- No combinational path from alu_result to any output; alu_* outputs depend only on the request inputs, slot state and pointer.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, adds outputs grant_cnt0, grant_cnt1 and conflict_cnt (each CNT_WIDTH, out):
  - grant_cnt0 / grant_cnt1 count grants per requester.
  - conflict_cnt counts cycles in which both req_valid are 1 and the slot is free.
  - All three saturate at all-ones and clear to 0 on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- req0 ctrl=000000, opA=4, opB=5, rsp_ready0=1 -> next cycle rsp_valid0=1, rsp_result=9, rsp_branch=0; rsp_valid1 stays 0.
- After reset, both requesters hold valid; req0 is ADD 4,5 and req1 is SUB (001000) 10,-5; both rsp_ready=1 -> results alternate 9, 15, 9, 15 with owners 0, 1, 0, 1 on consecutive cycles.
- rsp_ready0=0 for 3 cycles after the result 9 arrives -> rsp_valid0 and result 9 are held and both req_ready are 0. Then rsp_ready0=1 with req1 valid (SUB 10,-5) -> same-cycle grant to req1; next cycle rsp_valid1=1, result 15.
- req1 branch_op=1, ctrl=010000 (BEQ), opA=opB=FFFFFFFF -> rsp_branch=1. Repeat with ctrl=010001 (BNE) -> rsp_branch=0.
- Drive reset=0 while rsp_valid1=1 -> after the edge both rsp_valid are 0 and rsp_result=0. Both requesters then valid after reset release -> req0 is granted first.
- With ALU_ARB_STATS_EN, run the scenario-2 sequence for 4 grants -> grant_cnt0=2, grant_cnt1=2, conflict_cnt=4.
